// File: rtl/buzzer_melody_ctrl_pkg.sv
// Shared definitions for the buzzer melody controller: FSM states, default word width and
// the duration-tick divider computation.
package buzzer_melody_ctrl_pkg;

  localparam int unsigned N_DEFAULT = 9;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_NOTE,
    PLAY,
    GAP,
    DONE
  } state_e;

  // Clock cycles per duration tick, never less than one.
  function automatic int unsigned calc_tick_div(input int unsigned clk_fre,
                                                input int unsigned tick_hz);
    int unsigned div;
    div = clk_fre / tick_hz;
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/buzzer_melody_ctrl_tick_gen.sv
// Duration prescaler: counts clk cycles and flags the last cycle of each tick period.
// A synchronous restart pins the count at zero.
module buzzer_melody_ctrl_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/buzzer_melody_ctrl.sv
// Melody sequencer feeding a PWM tone generator: pulls notes over a valid/ready handshake,
// plays each for its tick length, inserts an optional silent gap and pulses done at the end.
module buzzer_melody_ctrl
  import buzzer_melody_ctrl_pkg::*;
#(
  parameter int unsigned N         = N_DEFAULT,
  parameter int unsigned CLK_FRE   = 50_000_000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned GAP_TICKS = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] duty_cfg,
  input  logic         note_valid,
  output logic         note_ready,
  input  logic [N-1:0] note_pitch,
  input  logic [7:0]   note_len,
  input  logic         note_last,
  output logic [N-1:0] period,
  output logic [N-1:0] duty,
  output logic         key,
  output logic         busy,
  output logic         done
);

  localparam int unsigned TICK_DIV = calc_tick_div(CLK_FRE, TICK_HZ);
  localparam logic [7:0] GAP_LAST = (GAP_TICKS > 0) ? 8'(GAP_TICKS - 1) : 8'd0;

  state_e     r_state;
  logic [7:0] r_len;
  logic [7:0] r_ticks;
  logic       r_last;

  logic w_tick;
  logic w_play_end;
  logic w_gap_end;
  logic w_restart;

  assign w_play_end = (r_state == PLAY) && w_tick && (r_ticks == r_len - 8'd1);
  assign w_gap_end  = (r_state == GAP) && w_tick && (r_ticks == GAP_LAST);
  // Hold the prescaler at zero outside timed states and across the PLAY->GAP boundary.
  assign w_restart  = !((r_state == PLAY) || (r_state == GAP)) || w_play_end || w_gap_end;

  buzzer_melody_ctrl_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_restart(w_restart),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      period     <= '0;
      duty       <= '0;
      key        <= 1'b1;
      note_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_len      <= '0;
      r_ticks    <= '0;
      r_last     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        r_state    <= IDLE;
        period     <= '0;
        key        <= 1'b1;
        note_ready <= 1'b0;
        busy       <= 1'b0;
        r_ticks    <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (start) begin
              r_state    <= WAIT_NOTE;
              duty       <= duty_cfg;
              note_ready <= 1'b1;
              busy       <= 1'b1;
              key        <= 1'b1;
            end
          end
          WAIT_NOTE: begin
            if (note_valid) begin
              r_state    <= PLAY;
              note_ready <= 1'b0;
              period     <= note_pitch;
              key        <= (note_pitch == '0);
              r_len      <= (note_len == 8'd0) ? 8'd1 : note_len;
              r_last     <= note_last;
              r_ticks    <= '0;
            end
          end
          PLAY: begin
            if (w_play_end) begin
              key     <= 1'b1;
              r_ticks <= '0;
              if (GAP_TICKS > 0) begin
                r_state <= GAP;
              end else begin
                r_state    <= r_last ? DONE : WAIT_NOTE;
                done       <= r_last;
                note_ready <= !r_last;
                period     <= r_last ? '0 : period;
              end
            end else if (w_tick) begin
              r_ticks <= r_ticks + 8'd1;
            end
          end
          GAP: begin
            if (w_gap_end) begin
              r_ticks    <= '0;
              r_state    <= r_last ? DONE : WAIT_NOTE;
              done       <= r_last;
              note_ready <= !r_last;
              period     <= r_last ? '0 : period;
            end else if (w_tick) begin
              r_ticks <= r_ticks + 8'd1;
            end
          end
          DONE: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
